div_clk_monitor: RTL and testbench
==================================

Name: div_clk_monitor

Overview:
- Sits directly downstream of the divide-by-32 stage.
- Samples the divided clock as an ordinary data signal in the clk_in domain and produces single-cycle rise/fall strobes for later logic.
- Measures each high and low run length in clk_in cycles and reports lock/error status against an expected half-period.
- Lets the team check divider health on-board and in simulation.

Parameters:
- EXP_HALF, 16, expected high/low run length in clk_in cycles (divide-by-32 gives 16).
- TOL, 0, allowed deviation ± in cycles; accept range is EXP_HALF-TOL .. EXP_HALF+TOL.
- LEN_W, 8, width of run-length counter and length outputs.
- EDGE_W, 16, width of edge counter.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  monitor enable.
- div_in  input  1  divided clock, generated synchronously from clk_in; no synchroniser required.
- err_clr  input  1  clears err_sticky.
- rise_pulse  output  1  one-cycle strobe per rising edge of div_in.
- fall_pulse  output  1  one-cycle strobe per falling edge of div_in.
- edge_count  output  EDGE_W  count of detected edges, both polarities.
- high_len  output  LEN_W  last completed high run length.
- low_len  output  LEN_W  last completed low run length.
- len_valid  output  1  one-cycle strobe when high_len or low_len updates.
- locked  output  1  waveform within tolerance.
- err_sticky  output  1  latched tolerance violation.

Behaviour:
- Reset (rst=1 at a clk_in edge): all outputs 0, internal d1/d2/run_cnt 0, state IDLE. Reset mid-operation aborts immediately; no partial lengths are published.
- Sampling pipeline:
  - d1<=div_in; d2<=d1 on every edge.
  - Edge is detected when d1!=d2 and state!=IDLE.
  - Strobes are registered: rise_pulse<=d1&~d2, fall_pulse<=~d1&d2 (gated by state!=IDLE).
  - Latency: div_in first sampled high at edge k -> rise_pulse high for exactly the cycle after edge k+1.
- run_cnt:
  - On a detected edge it reloads to 1; otherwise it increments.
  - Saturates at 2^LEN_W-1; no wrap.
- States:
  - IDLE: entered from reset, or at any edge where en=0.
    - run_cnt, locked and the good-run counter are cleared.
    - edge_count, lengths and err_sticky hold.
    - Leaves to ACQUIRE when en=1.
  - ACQUIRE: the first detected edge only restarts run_cnt, because the preceding run is partial. Nothing is published and edge_count still increments. Goes to MEASURE.
  - MEASURE: on each detected edge, the completed run is run_cnt before reload (the final run_cnt value before the transition).
    - Falling edge: published to high_len.
    - Rising edge: published to low_len.
    - len_valid pulses in the same cycle as the corresponding strobe.
- edge_count: +1 per detected edge in ACQUIRE/MEASURE; wraps modulo 2^EDGE_W.
- Lock:
  - Good-run counter (2 bits) increments per published in-range length, saturating at 2.
  - locked=1 when it reaches 2, i.e. one high and one low run both in range.
- Violation (MEASURE only). Either condition counts:
  - A published length is outside the accept range; a saturated value is always a violation.
  - run_cnt reaches EXP_HALF+TOL+1 with no edge (stuck input). This is flagged in the cycle after run_cnt takes that value, once per run.
- Violation effects: locked<=0, good-run counter<=0, err_sticky<=1. The state stays MEASURE.
- err_clr=1 clears err_sticky next cycle. A violation in the same cycle wins; err_sticky stays 1.
- en falling while locked: next cycle locked=0, no strobes. The pipeline d1/d2 keeps sampling so that re-enable produces no false edge from stale data.

Test Plan:
- rst held 3 cycles, then release with en=1, driven by the /32 divider (EXP_HALF=16, TOL=0):
  - First rise_pulse 2 cycles after div_in first sampled high; no len_valid on that edge.
  - Next fall: high_len=16, len_valid=1.
  - Next rise: low_len=16, locked=1.
  - edge_count=3; err_sticky=0.
- Hold div_in high 20 cycles while locked:
  - err_sticky=1 and locked=0 in the cycle after run_cnt reaches 17.
  - Subsequent fall publishes high_len=20.
  - Two good runs later, locked=1 again.
- Drive a 15-cycle low run:
  - low_len=15, err_sticky=1, locked=0.
  - With TOL=1 the same stimulus keeps locked=1 and err_sticky=0.
- Assert err_clr in the same cycle as a violation:
  - err_sticky stays 1.
  - err_clr alone on the next cycle -> err_sticky=0.
- en=0 mid-high run for 10 cycles, then en=1:
  - No strobes while disabled; locked=0.
  - First edge after re-enable publishes nothing; lock regained after one high and one low run of 16.
- Force edge_count to 2^EDGE_W-1 (EDGE_W=4, 15 edges), then one more edge -> edge_count=0; rst mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: edge strobes, run-length measurement and lock/error status for a divided clock
// Ports:
//   clk_in      system clock
//   rst         synchronous active-high reset
//   en          monitor enable
//   div_in      divided clock, synchronous to clk_in, treated as data
//   err_clr     clears err_sticky
//   rise_pulse  one-cycle strobe per rising edge of div_in
//   fall_pulse  one-cycle strobe per falling edge of div_in
//   edge_count  detected edges, both polarities, wrapping
//   high_len    last completed high run length
//   low_len     last completed low run length
//   len_valid   strobe when high_len or low_len updates
//   locked      one high and one low run in tolerance since the last violation
//   err_sticky  latched tolerance violation
module div_clk_monitor #(
   parameter int EXP_HALF = 16,
   parameter int TOL      = 0,
   parameter int LEN_W    = 8,
   parameter int EDGE_W   = 16
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic              div_in,
   input  logic              err_clr,
   output logic              rise_pulse,
   output logic              fall_pulse,
   output logic [EDGE_W-1:0] edge_count,
   output logic [LEN_W-1:0]  high_len,
   output logic [LEN_W-1:0]  low_len,
   output logic              len_valid,
   output logic              locked,
   output logic              err_sticky
);
   typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;
   localparam logic [LEN_W-1:0] LEN_MAX = '1;
   localparam logic [LEN_W-1:0] LO      = LEN_W'(EXP_HALF - TOL);
   localparam logic [LEN_W-1:0] HI      = LEN_W'(EXP_HALF + TOL);
   localparam logic [LEN_W-1:0] STUCK   = LEN_W'(EXP_HALF + TOL + 1);
   state_t           state;
   logic             d1, d2;
   logic [LEN_W-1:0] run_cnt;
   logic [1:0]       good;
   logic             edge_det, pub, in_range, stuck, viol;
   always_comb begin
      edge_det = en && state != IDLE && d1 != d2;
      pub      = edge_det && state == MEASURE;
      // a saturated count is never a legal length, even if the window reaches it
      in_range = run_cnt >= LO && run_cnt <= HI && run_cnt != LEN_MAX;
      // run_cnt only passes through STUCK once per run; if STUCK is the
      // saturation value the repeated flag is harmless (all effects idempotent)
      stuck    = en && state == MEASURE && !edge_det && run_cnt == STUCK;
      viol     = (pub && !in_range) || stuck;
   end
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state      <= IDLE;
         d1         <= 1'b0;
         d2         <= 1'b0;
         run_cnt    <= '0;
         good       <= 2'd0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         edge_count <= '0;
         high_len   <= '0;
         low_len    <= '0;
         len_valid  <= 1'b0;
         locked     <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         // the pipeline samples even when disabled so re-enable sees no stale edge
         d1         <= div_in;
         d2         <= d1;
         rise_pulse <= edge_det && d1;
         fall_pulse <= edge_det && !d1;
         len_valid  <= pub;
         err_sticky <= viol || (err_sticky && !err_clr);
         if (edge_det) edge_count <= edge_count + EDGE_W'(1);
         // the run just completed is the count before reload: d2 high means a high run ended
         if (pub && d2) high_len <= run_cnt;
         if (pub && d1) low_len <= run_cnt;
         if (!en) begin
            state   <= IDLE;
            run_cnt <= '0;
            good    <= 2'd0;
            locked  <= 1'b0;
         end else begin
            state   <= state == IDLE ? ACQUIRE : edge_det ? MEASURE : state;
            run_cnt <= state == IDLE ? '0 : edge_det ? LEN_W'(1) :
                       run_cnt == LEN_MAX ? run_cnt : run_cnt + LEN_W'(1);
            // a publish without violation is in range, so it advances the good-run count
            good    <= viol ? 2'd0 : !pub ? good : good == 2'd2 ? 2'd2 : good + 2'd1;
            locked  <= !viol && (pub ? good != 2'd0 : locked);
         end
      end
   end
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: scoreboard bench for div_clk_monitor driven by run-length stimulus
module tb_div_clk_monitor;
   localparam int EXP_HI = 16;
   logic        clk_in = 1'b0, rst = 1'b1, en = 1'b1, div_in = 1'b0, err_clr = 1'b0;
   logic        rise0, fall0, lv0, lk0, err0;
   logic [15:0] ec0;
   logic [7:0]  hl0, ll0;
   logic        rise1, fall1, lv1, lk1, err1;
   logic [15:0] ec1;
   logic [7:0]  hl1, ll1;
   logic        rise2, fall2, lv2, lk2, err2;
   logic [3:0]  ec2;
   logic [7:0]  hl2, ll2;
   int          n_vec = 0, n_bad = 0;
   typedef struct {logic hi; int len; logic lk; logic er;} pub_t;
   pub_t        sb[$];
   pub_t        p;
   bit          cur_lvl = 1'b0, act = 1'b1, armed = 1'b0, exp_err = 1'b0;
   int          prev_len = 0, good = 0, exp_edges = 0;

   div_clk_monitor dut0 (.clk_in(clk_in), .rst(rst), .en(en), .div_in(div_in), .err_clr(err_clr),
      .rise_pulse(rise0), .fall_pulse(fall0), .edge_count(ec0), .high_len(hl0), .low_len(ll0),
      .len_valid(lv0), .locked(lk0), .err_sticky(err0));
   div_clk_monitor #(.TOL(1)) dut1 (.clk_in(clk_in), .rst(rst), .en(en), .div_in(div_in), .err_clr(err_clr),
      .rise_pulse(rise1), .fall_pulse(fall1), .edge_count(ec1), .high_len(hl1), .low_len(ll1),
      .len_valid(lv1), .locked(lk1), .err_sticky(err1));
   div_clk_monitor #(.EDGE_W(4)) dut2 (.clk_in(clk_in), .rst(rst), .en(en), .div_in(div_in), .err_clr(err_clr),
      .rise_pulse(rise2), .fall_pulse(fall2), .edge_count(ec2), .high_len(hl2), .low_len(ll2),
      .len_valid(lv2), .locked(lk2), .err_sticky(err2));

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // hold div_in at lvl for n cycles; err_clr follows clr[i] for the first 4 cycles
   task automatic run(input bit lvl, input int n, input logic [3:0] clr = 4'b0);
      bit e, v;
      e = lvl != cur_lvl;
      if (e && act) begin
         exp_edges++;
         if (armed) begin
            v = prev_len != EXP_HI;
            exp_err = exp_err | v;
            good = v ? 0 : (good == 2 ? 2 : good + 1);
            sb.push_back('{cur_lvl, prev_len, good == 2, exp_err});
         end
         armed = 1'b1;
      end
      prev_len = e ? n : prev_len + n;
      cur_lvl = lvl;
      for (int i = 0; i < n; i++) begin
         div_in = lvl;
         err_clr = i < 4 ? clr[i] : 1'b0;
         @(negedge clk_in);
         if (e && i >= 1 && i <= 3)
            check("strobe", {rise0, fall0}, (i == 2 && act) ? {lvl, !lvl} : 2'b00);
         if (e && i == 2) begin
            check("edge_count", ec0, exp_edges % 65536);
            check("edge_count_w4", ec2, exp_edges % 16);
         end
         if (i == 3 && clr[2]) begin
            check("err_clr", err0, 0);
            exp_err = 1'b0;
         end
         if (e && act && armed && n >= EXP_HI + 4) begin
            if (i == EXP_HI + 2) check("pre_stuck", {err0, lk0}, {exp_err, good == 2});
            if (i == EXP_HI + 3) begin
               check("stuck", {err0, lk0}, 2'b10);
               exp_err = 1'b1;
               good = 0;
            end
         end
         @(posedge clk_in);
         #1;
      end
      err_clr = 1'b0;
   endtask

   always @(negedge clk_in) begin
      if (lv0 === 1'b1) begin
         if (sb.size() == 0) check("sb_extra", 1, 0);
         else begin
            p = sb.pop_front();
            check("pub_dir", {fall0, rise0}, {p.hi, !p.hi});
            check("pub_len", p.hi ? hl0 : ll0, p.len);
            check("pub_lock", lk0, p.lk);
            check("pub_err", err0, p.er);
         end
      end
   end

   initial begin
      @(posedge clk_in);
      @(negedge clk_in);
      check("reset", {rise0, fall0, ec0, hl0, ll0, lv0, lk0, err0}, 0);
      @(posedge clk_in);
      @(posedge clk_in);
      #1;
      rst = 1'b0;
      run(0, 5); run(1, 16); run(0, 16); run(1, 16);
      check("lock_a", lk0, 1);
      check("err_a", err0, 0);
      check("edges_a", ec0, 3);
      run(0, 15); run(1, 16);
      check("err_b", {err0, lk0}, 2'b10);
      check("tol1", {err1, lk1}, 2'b01);
      run(0, 16); run(1, 16);
      run(0, 15); run(1, 16, 4'b0110); run(0, 16); run(1, 16);
      run(0, 16); run(1, 20); run(0, 16); run(1, 16); run(0, 16);
      check("relock_d", lk0, 1);
      run(1, 5);
      en = 1'b0; act = 1'b0; armed = 1'b0; good = 0;
      run(1, 5);
      check("dis_lock", lk0, 0);
      run(0, 5);
      en = 1'b1; act = 1'b1;
      run(0, 6); run(1, 16); run(0, 16); run(1, 16);
      check("relock_e", lk0, 1);
      run(0, 5);
      rst = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      check("mid_reset", {rise0, fall0, ec0, hl0, ll0, lv0, lk0, err0}, 0);
      check("mid_reset_w4", {rise2, fall2, ec2, hl2, ll2, lv2, lk2, err2}, 0);
      check("sb_left", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
